slot_reel_judge: RTL and testbench



---
 rtl/slot_reel_judge_if.sv | 18 +
 rtl/slot_reel_judge.sv | 119 +++++++++++
 tb/tb_slot_reel_judge.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/slot_reel_judge_if.sv
// slot_reel_judge_if: player buttons in, reel digits and game result out
//   start, stop        : active-high button levels (master drives)
//   reel0, reel1, reel2: live or frozen reel digits (slave drives)
//   spinning, win, lose: game status (slave drives)
//   pair_win           : pair-only win flag, present only when PAIR_WIN_EN is defined
interface slot_reel_judge_if;
    logic       start, stop;
    logic [3:0] reel0, reel1, reel2;
    logic       spinning, win, lose;
`ifdef PAIR_WIN_EN
    logic [3:0] pair_win;
    modport master(output start, stop, input reel0, reel1, reel2, spinning, win, lose, pair_win);
    modport slave(input start, stop, output reel0, reel1, reel2, spinning, win, lose, pair_win);
`else
    modport master(output start, stop, input reel0, reel1, reel2, spinning, win, lose);
    modport slave(input start, stop, output reel0, reel1, reel2, spinning, win, lose);
`endif
endinterface

// File: rtl/slot_reel_judge.sv
// slot_reel_judge: three-reel slot core; steps reels on a divided clock, stops them one by one, judges win/lose
//   clock  : system clock, posedge
//   resetn : synchronous active-low reset
//   io     : slot_reel_judge_if.slave (start/stop in; reel0..2, spinning, win, lose out)
//   Optional macro PAIR_WIN_EN: a two-reel match also wins and io.pair_win[0] flags it
module slot_reel_judge #(
    parameter int TICK_DIV  = 2500000,
    parameter int DIGIT_MAX = 9
) (
    input logic               clock,
    input logic               resetn,
    slot_reel_judge_if.slave  io
);
    localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [2:0] {IDLE, SPIN3, SPIN2, SPIN1, JUDGE, DONE} state_t;
    state_t        state, state_nx;
    logic [1:0]    start_sync, stop_sync;
    logic          start_prev, stop_prev, start_p, stop_p, step, spin_st, triple, pair, hit;
    logic [CW-1:0] cnt;
    logic [3:0]    r0, r1, r2;
    logic          win_q, lose_q;
`ifdef PAIR_WIN_EN
    logic [3:0]    pair_q;
`endif

    function automatic logic [3:0] adv(input logic [3:0] r, input logic [3:0] k);
        logic [4:0] s;
        s = {1'b0, r} + {1'b0, k};
        return s > 5'(DIGIT_MAX) ? 4'(s - 5'(DIGIT_MAX + 1)) : s[3:0];
    endfunction

    assign start_p = start_sync[1] & ~start_prev;
    assign stop_p  = stop_sync[1] & ~stop_prev;
    assign step    = cnt == CW'(TICK_DIV - 1);
    assign triple  = r0 == r1 && r1 == r2;
    assign pair    = !triple && (r0 == r1 || r1 == r2 || r0 == r2);
`ifdef PAIR_WIN_EN
    assign hit     = triple | pair;
`else
    assign hit     = triple;
`endif

    always_ff @(posedge clock) begin
        if (!resetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = start_p ? SPIN3 : state;
            SPIN3:      state_nx = stop_p ? SPIN2 : state;
            SPIN2:      state_nx = stop_p ? SPIN1 : state;
            SPIN1:      state_nx = stop_p ? JUDGE : state;
            JUDGE:      state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        spin_st = state == SPIN3 || state == SPIN2 || state == SPIN1;
    end

    // A stop press wins over a coincident step for the reel it freezes only.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            start_sync <= '0;
            stop_sync  <= '0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
            cnt        <= '0;
            r0         <= '0;
            r1         <= '0;
            r2         <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
`ifdef PAIR_WIN_EN
            pair_q     <= '0;
`endif
        end else begin
            start_sync <= {start_sync[0], io.start};
            stop_sync  <= {stop_sync[0], io.stop};
            start_prev <= start_sync[1];
            stop_prev  <= stop_sync[1];
            cnt        <= spin_st && !step ? cnt + CW'(1) : '0;
            if (step && state == SPIN3 && !stop_p)
                r0 <= adv(r0, 4'd1);
            if (step && (state == SPIN3 || (state == SPIN2 && !stop_p)))
                r1 <= adv(r1, 4'd3);
            if (step && (state == SPIN3 || state == SPIN2 || (state == SPIN1 && !stop_p)))
                r2 <= adv(r2, 4'd7);
            if (state == JUDGE) begin
                win_q  <= hit;
                lose_q <= !hit;
`ifdef PAIR_WIN_EN
                pair_q <= {3'b000, pair};
`endif
            end else if (state == DONE && start_p) begin
                win_q  <= 1'b0;
                lose_q <= 1'b0;
`ifdef PAIR_WIN_EN
                pair_q <= '0;
`endif
            end
        end
    end

    assign io.reel0    = r0;
    assign io.reel1    = r1;
    assign io.reel2    = r2;
    assign io.spinning = spin_st;
    assign io.win      = win_q;
    assign io.lose     = lose_q;
`ifdef PAIR_WIN_EN
    assign io.pair_win = pair_q;
`endif
endmodule

// File: tb/tb_slot_reel_judge.sv
// tb_slot_reel_judge: directed table, corner sequences and random play against a game-level model
module tb_slot_reel_judge;
    localparam int TD = 4;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    slot_reel_judge_if bus();
    slot_reel_judge #(.TICK_DIV(TD)) dut (.clock(clock), .resetn(resetn), .io(bus.slave));

    typedef struct {
        logic rn, st, sp;
        int   n;
        logic [3:0] r0, r1, r2;
        logic spin, win, lose;
    } vec_t;
    vec_t tbl[$];

    int pass_cnt = 0;
    int total_cnt = 0;

    int m_reel[3] = '{0, 0, 0};
    int inc[3] = '{1, 3, 7};
    int m_moving = 0;
    int m_ph = 0;
    bit m_judge = 0, m_done = 0, m_win = 0, m_lose = 0, m_pair = 0;
    bit hs[$] = '{0, 0, 0, 0};
    bit hp[$] = '{0, 0, 0, 0};

    function automatic vec_t mk(logic rn, logic st, logic sp, int n, logic [3:0] r0, logic [3:0] r1,
                                logic [3:0] r2, logic spin, logic win, logic lose);
        vec_t v;
        v = '{rn, st, sp, n, r0, r1, r2, spin, win, lose};
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Game-level model: a press is a button that was up three edges ago and down two edges ago.
    task automatic model_edge();
        bit sp, tp, step, triple, pair;
        int mv;
        if (!resetn) begin
            m_reel = '{0, 0, 0};
            m_moving = 0; m_ph = 0;
            m_judge = 0; m_done = 0; m_win = 0; m_lose = 0; m_pair = 0;
            hs = '{0, 0, 0, 0};
            hp = '{0, 0, 0, 0};
            return;
        end
        hs.push_front(bus.start); void'(hs.pop_back());
        hp.push_front(bus.stop);  void'(hp.pop_back());
        sp = hs[2] && !hs[3];
        tp = hp[2] && !hp[3];
        mv = m_moving;
        step = mv > 0 && m_ph == TD - 1;
        for (int i = 0; i < 3; i++)
            if (step && i >= 3 - mv && !(tp && i == 3 - mv))
                m_reel[i] = (m_reel[i] + inc[i]) % 10;
        m_ph = mv > 0 ? (m_ph + 1) % TD : 0;
        if (m_judge) begin
            triple = m_reel[0] == m_reel[1] && m_reel[1] == m_reel[2];
            pair = !triple && (m_reel[0] == m_reel[1] || m_reel[1] == m_reel[2] || m_reel[0] == m_reel[2]);
`ifdef PAIR_WIN_EN
            m_win = triple || pair;
            m_pair = pair;
`else
            m_win = triple;
            m_pair = 0;
`endif
            m_lose = !m_win;
            m_judge = 0;
            m_done = 1;
        end else if (mv > 0 && tp) begin
            m_moving--;
            if (m_moving == 0) m_judge = 1;
        end else if (mv == 0 && sp) begin
            m_moving = 3;
            m_done = 0; m_win = 0; m_lose = 0; m_pair = 0;
        end
    endtask

    task automatic compare_model();
        logic [3:0] pw;
        logic [31:0] got, exp;
`ifdef PAIR_WIN_EN
        pw = bus.pair_win;
`else
        pw = 4'd0;
`endif
        got = {13'd0, pw, bus.reel0, bus.reel1, bus.reel2, bus.spinning, bus.win, bus.lose};
        exp = {13'd0, 3'd0, m_pair, 4'(m_reel[0]), 4'(m_reel[1]), 4'(m_reel[2]), m_moving > 0, m_win, m_lose};
        chk("model", got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic press_stop();
        bus.stop = 1'b1; tick();
        bus.stop = 1'b0; tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stop = 1'b0;
        //            rn st sp  n  r0 r1 r2 spin win lose
        tbl.push_back(mk(0, 0, 0,  3, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 50, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  2, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  8, 2, 6, 4, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 10, 4, 2, 8, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 4, 2, 8, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  3, 5, 5, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 34, 5, 5, 8, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 5, 5, 8, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0, 20, 5, 5, 5, 0, 1, 0));
        tbl.push_back(mk(1, 1, 0,  1, 5, 5, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 1,  1, 5, 5, 5, 0, 1, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1,  1, 5, 5, 5, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 2, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 2, 0, 0, 0));
`ifdef PAIR_WIN_EN
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 2, 0, 1, 0));
`else
        tbl.push_back(mk(1, 0, 0,  1, 5, 5, 2, 0, 0, 1));
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            resetn = tbl[i].rn;
            bus.start = tbl[i].st;
            bus.stop = tbl[i].sp;
            repeat (tbl[i].n) tick();
            chk($sformatf("row%0d_reels", i), {20'd0, bus.reel0, bus.reel1, bus.reel2},
                {20'd0, tbl[i].r0, tbl[i].r1, tbl[i].r2});
            chk($sformatf("row%0d_flags", i), {29'd0, bus.spinning, bus.win, bus.lose},
                {29'd0, tbl[i].spin, tbl[i].win, tbl[i].lose});
        end
`ifdef PAIR_WIN_EN
        chk("pair_win_flag", {28'd0, bus.pair_win}, 32'd1);
`endif

        // held stop: only the first press counts
        bus.start = 1'b1; tick();
        bus.start = 1'b0; tick(); tick();
        chk("restart_spin", {31'd0, bus.spinning}, 32'd1);
        bus.stop = 1'b1;
        repeat (30) tick();
        chk("held_stop_spin", {31'd0, bus.spinning}, 32'd1);

        // start in SPIN2 ignored: two more stops must finish the game
        bus.stop = 1'b0;
        bus.start = 1'b1; tick();
        bus.start = 1'b0; repeat (4) tick();
        chk("start_in_spin2", {31'd0, bus.spinning}, 32'd1);
        press_stop();
        press_stop();
        repeat (4) tick();
        chk("finish_spin", {31'd0, bus.spinning}, 32'd0);
        chk("finish_result", {30'd0, bus.win, bus.lose} == 2'b10 || {bus.win, bus.lose} == 2'b01, 32'd1);

        // start and stop together in DONE restart the spin
        bus.start = 1'b1; bus.stop = 1'b1; tick();
        bus.start = 1'b0; bus.stop = 1'b0; tick(); tick();
        chk("both_in_done", {29'd0, bus.spinning, bus.win, bus.lose}, 32'b100);

        // reset while in SPIN1
        press_stop();
        press_stop();
        tick(); tick();
        chk("in_spin1", {31'd0, bus.spinning}, 32'd1);
        resetn = 1'b0; tick();
        chk("mid_reset", {13'd0, bus.reel0, bus.reel1, bus.reel2, bus.spinning, bus.win, bus.lose,
                          4'd0}, 32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 3) == 0) bus.stop = ~bus.stop;
            resetn = $urandom_range(0, 599) != 0;
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
